// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and hazard controller state.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        HALT
    } hazard_state_t;

    // Load in EX whose destination is read by the instruction in decode.
    function automatic logic is_load_use(input logic     ex_dren,
                                         input regbits_t ex_rt,
                                         input regbits_t id_rs,
                                         input regbits_t id_rt,
                                         input logic     id_uses_rt);
        return ex_dren && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_unit_perf_cnt.sv
// Saturating performance counter bank for the hazard controller.
module hazard_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             stall_inc,
    input  logic             flush_inc,
    input  logic             bubble_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] bubble_cycles
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles  <= '0;
            flush_events  <= '0;
            bubble_cycles <= '0;
        end else begin
            if (stall_inc && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush_inc && (flush_events != '1))
                flush_events <= flush_events + 1'b1;
            if (bubble_inc && (bubble_cycles != '1))
                bubble_cycles <= bubble_cycles + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stage enables/flushes, PC control, memory gating, sticky halt.
// Optional performance counters under `HAZARD_PERF_CNT_EN.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_dren,
    input  regbits_t         ex_rt,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             mem_br_taken,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             pc_sel_br,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             imem_ren,
    output logic             dmem_ren,
    output logic             dmem_wen,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] bubble_cycles,
`endif
    output logic             halt
);

    hazard_state_t state, state_nxt;
    logic mem_req, load_use, active;
    logic stall_ev, flush_ev, bubble_ev;

    always_comb begin
        mem_req     = mem_dren | mem_dwen;
        load_use    = is_load_use(ex_dren, ex_rt, id_rs, id_rt, id_uses_rt);
        active      = (state != HALT);
        state_nxt   = state;
        pc_en       = 1'b0;
        pc_sel_br   = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        bubble_ev   = 1'b0;

        if (active) begin
            if (wb_halt) begin
                state_nxt = HALT;
            end else if (((state == DWAIT) || mem_req) && !dhit) begin
                state_nxt = DWAIT;
                stall_ev  = 1'b1;
            end else begin
                state_nxt = RUN;
                idex_en   = 1'b1;
                exmem_en  = 1'b1;
                memwb_en  = 1'b1;
                if (mem_br_taken) begin
                    flush_ev    = 1'b1;
                    pc_en       = 1'b1;
                    pc_sel_br   = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    // IF/ID and PC hold; ID/EX loads a bubble behind the load.
                    bubble_ev  = 1'b1;
                    idex_flush = 1'b1;
                end else if (!ihit) begin
                    bubble_ev  = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
        end
    end

    // The data access owns the shared memory port while it is pending.
    assign imem_ren = active & ~mem_req;
    assign dmem_ren = active & mem_dren;
    assign dmem_wen = active & mem_dwen;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
            halt  <= 1'b0;
        end else begin
            state <= state_nxt;
            halt  <= (state_nxt == HALT);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
        .CLK           (CLK),
        .nRST          (nRST),
        .stall_inc     (stall_ev),
        .flush_inc     (flush_ev),
        .bubble_inc    (bubble_ev),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events),
        .bubble_cycles (bubble_cycles)
    );
`else
    // CNT_W only sizes the counter bank; keep it referenced in the plain build.
    if (CNT_W == 0) begin : g_cnt_w_unused
    end
    logic unused_ev;
    assign unused_ev = stall_ev ^ flush_ev ^ bubble_ev;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed hazard cases then randomized traffic.
module tb_hazard_unit;

    localparam int unsigned CW = 4;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       ihit, dhit, id_uses_rt, ex_dren, mem_dren, mem_dwen, mem_br_taken, wb_halt;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       pc_en, pc_sel_br, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, imem_ren, dmem_ren, dmem_wen, halt;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cycles, flush_events, bubble_cycles;
`endif

    hazard_unit #(.CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dren(ex_dren), .ex_rt(ex_rt),
        .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_br_taken(mem_br_taken),
        .wb_halt(wb_halt),
        .pc_en(pc_en), .pc_sel_br(pc_sel_br),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .imem_ren(imem_ren), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles), .flush_events(flush_events), .bubble_cycles(bubble_cycles),
`endif
        .halt(halt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ih, dh;
        logic [4:0] rs, rt;
        logic       urt, exd;
        logic [4:0] ert;
        logic       md, mw, br, wh;
    } stim_t;

    typedef struct {
        string       name;
        logic [12:0] vec;
        int unsigned stall, flush, bubble;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: halted / waiting flags and event totals.
    bit          m_halted = 0;
    bit          m_wait   = 0;
    int unsigned m_stall = 0, m_flush = 0, m_bubble = 0;

    // {pc_en, pc_sel_br, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl}
    // index: 0 halted, 1 wb_halt, 2 freeze, 3 branch, 4 load-use, 5 fetch bubble, 6 advance
    logic [8:0] ctrl_tab [7] = '{9'b0, 9'b0, 9'b0, 9'b111111111, 9'b000111010,
                                 9'b001111100, 9'b101111000};

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s    = '0;
        s.ih = 1'b1;
        return s;
    endfunction

    function automatic int unsigned sat(int unsigned v);
        return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
    endfunction

    task automatic step(input stim_t s, input string name);
        int   rule;
        bit   mreq, lu;
        exp_t e;
        @(negedge CLK);
        ihit = s.ih; dhit = s.dh; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt;
        ex_dren = s.exd; ex_rt = s.ert; mem_dren = s.md; mem_dwen = s.mw;
        mem_br_taken = s.br; wb_halt = s.wh;
        #1;
        mreq = s.md | s.mw;
        lu   = s.exd && (s.ert != 0) && ((s.ert == s.rs) || (s.urt && (s.ert == s.rt)));
        if (m_halted)                    rule = 0;
        else if (s.wh)                   rule = 1;
        else if ((m_wait || mreq) && !s.dh) rule = 2;
        else if (s.br)                   rule = 3;
        else if (lu)                     rule = 4;
        else if (!s.ih)                  rule = 5;
        else                             rule = 6;
        e.name   = name;
        e.vec    = {ctrl_tab[rule], !m_halted && !mreq, s.md && !m_halted,
                    s.mw && !m_halted, m_halted};
        e.stall  = m_stall;
        e.flush  = m_flush;
        e.bubble = m_bubble;
        q.push_back(e);
        if (rule == 2) m_stall = sat(m_stall);
        if (rule == 3) m_flush = sat(m_flush);
        if (rule == 4 || rule == 5) m_bubble = sat(m_bubble);
        m_halted = m_halted || (rule == 1);
        m_wait   = (rule == 2);
    endtask

    // Reset asserted mid-cycle; halt must clear before the next clock edge.
    task automatic do_reset(input string name);
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1 check({name, "_halt"}, {31'b0, halt}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check({name, "_cnt"}, {20'b0, stall_cycles, flush_events, bubble_cycles}, 32'd0);
`endif
        m_halted = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_bubble = 0;
        @(posedge CLK);
        #2 nRST = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge CLK);
            #2;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check(e.name, {19'b0, pc_en, pc_sel_br, ifid_en, idex_en, exmem_en, memwb_en,
                               ifid_flush, idex_flush, exmem_flush, imem_ren, dmem_ren,
                               dmem_wen, halt}, {19'b0, e.vec});
`ifdef HAZARD_PERF_CNT_EN
                check({e.name, "_cnt"}, {20'b0, stall_cycles, flush_events, bubble_cycles},
                      {20'b0, e.stall[CW-1:0], e.flush[CW-1:0], e.bubble[CW-1:0]});
`endif
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        stim_t r;
        int    halt_len;
        {ihit, dhit, id_uses_rt, ex_dren, mem_dren, mem_dwen, mem_br_taken, wb_halt} = '0;
        {id_rs, id_rt, ex_rt} = '0;
        #2 check("reset_halt", {31'b0, halt}, 32'd0);
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;

        step(idle(), "run");
        s = idle(); s.exd = 1; s.ert = 5; s.rs = 5;
        step(s, "load_use_rs");
        step(idle(), "after_load_use");
        s.ert = 0; s.rs = 0;
        step(s, "load_use_r0");
        s = idle(); s.exd = 1; s.ert = 7; s.rt = 7; s.rs = 2; s.urt = 1;
        step(s, "load_use_rt");
        s.urt = 0;
        step(s, "no_use_rt");
        s = idle(); s.md = 1;
        repeat (3) step(s, "dmiss_wait");
        s.dh = 1;
        step(s, "dmiss_hit");
        step(idle(), "after_dmiss");
        s = idle(); s.br = 1; s.exd = 1; s.ert = 3; s.rs = 3; s.ih = 0;
        step(s, "branch_lu_nohit");
        s = idle(); s.ih = 0;
        step(s, "fetch_bubble");
        s = idle(); s.mw = 1; s.dh = 1;
        step(s, "store_hit");
        s = idle(); s.wh = 1;
        step(s, "wb_halt");
        repeat (10) step(idle(), "halted");
        do_reset("halt_reset");
        s = idle(); s.md = 1;
        step(s, "dwait_entry");
        step(s, "dwait_hold");
        do_reset("dwait_reset");
        step(idle(), "after_dwait_reset");

        halt_len = 0;
        r = idle();
        for (int unsigned i = 0; i < 1500; i++) begin
            if (m_halted && halt_len >= 4) begin
                do_reset("rand_reset");
                halt_len = 0;
            end else if (m_wait && $urandom_range(0, 40) == 0) begin
                do_reset("rand_dwait_reset");
            end
            if (!m_wait) begin
                r.md = ($urandom_range(0, 3) == 0);
                r.mw = !r.md && ($urandom_range(0, 5) == 0);
            end
            r.ih  = ($urandom_range(0, 3) != 0);
            r.dh  = ($urandom_range(0, 2) == 0);
            r.rs  = 5'($urandom_range(0, 3));
            r.rt  = 5'($urandom_range(0, 3));
            r.ert = 5'($urandom_range(0, 3));
            r.urt = 1'($urandom);
            r.exd = ($urandom_range(0, 2) == 0);
            r.br  = ($urandom_range(0, 5) == 0);
            r.wh  = !m_wait && ($urandom_range(0, 60) == 0);
            step(r, "random");
            if (m_halted) halt_len++;
        end

        @(negedge CLK);
        #5;
        check("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Control-side counterpart to the pipeline register bank. The register bank latches stage state; this block decides, every cycle, which register stages load, which are cleared to bubbles, and whether the PC advances.
- Watches register outputs from the ID/EX, EX/MEM and MEM/WB stages plus cache hit lines.
- Drives per-stage enable/flush controls, PC control, memory request gating and the sticky processor halt.
- Sits in the datapath top level between the cache interfaces and the pipeline registers.

Parameters:
- CNT_W, 32, width of each performance counter (used only with the optional feature).

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  icache returned the fetch word this cycle
- dhit  in  1  dcache completed the MEM-stage access this cycle
- id_rs  in  5  rs field of the instruction in decode (regbits_t)
- id_rt  in  5  rt field of the instruction in decode
- id_uses_rt  in  1  decode instruction reads rt
- ex_dren  in  1  ID/EX-stage instruction is a load
- ex_rt  in  5  ID/EX-stage rt (load destination)
- mem_dren  in  1  EX/MEM-stage dREN
- mem_dwen  in  1  EX/MEM-stage dWEN
- mem_br_taken  in  1  EX/MEM stage resolved a taken branch or jump
- wb_halt  in  1  MEM/WB-stage halt flag
- pc_en  out  1  PC register load
- pc_sel_br  out  1  PC loads the redirect target
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load
- ifid_flush, idex_flush, exmem_flush  out  1 each  stage loads a bubble (all controls 0)
- imem_ren  out  1  instruction fetch request
- dmem_ren, dmem_wen  out  1 each  gated data request
- halt  out  1  sticky processor halt

Behaviour:
- States (hazard_state_t): RUN, DWAIT, HALT. Asynchronous reset forces RUN and halt=0.
- Reset values of registered outputs: halt=0. All combinational outputs resolve from RUN with inputs.
- mem_req = mem_dren | mem_dwen.
- load_use = ex_dren & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- Per-cycle priority in RUN, or in DWAIT with dhit:
  1. wb_halt: all enables 0, pc_en=0, no flushes. Next state HALT.
  2. mem_req & !dhit: freeze (all en=0, pc_en=0). Next state DWAIT.
  3. mem_br_taken: all en=1; ifid_flush, idex_flush and exmem_flush all set; pc_en=1, pc_sel_br=1. Younger 3 stages are squashed.
  4. load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. One-cycle stall; repeats while the condition holds.
  5. !ihit: pc_en=0, ifid_flush=1, other stages advance (fetch bubble).
  6. Otherwise: all en=1, pc_en=1, no flush.
- Flush takes effect only with the matching en=1. The flush wins over data for that stage.
- Stage-enable rule:
  - Load-use takes priority over !ihit: IF/ID holds, no flush.
  - ihit coincident with a taken branch: the fetched word is discarded via ifid_flush.
- DWAIT:
  - Outputs as rule 2 until dhit.
  - On dhit, evaluate rules 3-6 in the same cycle and return to RUN.
  - wb_halt cannot assert in DWAIT, because MEM/WB is frozen there.
- imem_ren = (state != HALT) & !mem_req. The data access owns the shared memory port.
- dmem_ren = mem_dren & (state != HALT). dmem_wen = mem_dwen & (state != HALT).
- HALT:
  - All enables, pc_en and imem/dmem requests are 0; halt=1, registered one cycle after wb_halt.
  - Exits only on nRST.
- Reset mid-DWAIT: return to RUN immediately. The pending access is abandoned because the request is gated by state and inputs.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cycles, flush_events and bubble_cycles, each CNT_W wide:
  - stall_cycles counts cycles of rule 2 or DWAIT.
  - flush_events counts rule-3 cycles.
  - bubble_cycles counts rule 4 and rule 5 cycles.
- Counters reset to 0 asynchronously, freeze in HALT, and saturate at all-ones.
- When undefined: ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg gains hazard_state_t (RUN, DWAIT, HALT); regbits_t is reused.
- One natural sub-module, hazard_perf_cnt: a saturating counter bank instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use stall:
  - Stimulus: ex_dren=1, ex_rt=5, id_rs=5, ihit=1.
  - Response: pc_en=0, ifid_en=0, idex_flush=1, memwb_en=1 for exactly that cycle.
  - With ex_rt=0: no stall.
- Data miss wait:
  - Stimulus: mem_dren=1, dhit=0 for 3 cycles, then dhit=1.
  - Response: 3 frozen cycles with imem_ren=0 and state DWAIT; full advance on the dhit cycle; RUN afterwards.
- Taken branch with concurrent load_use and !ihit:
  - Stimulus: mem_br_taken=1, load_use true, ihit=0.
  - Response: ifid/idex/exmem flush=1, pc_sel_br=1, pc_en=1.
- Fetch bubble:
  - Stimulus: ihit=0, no other hazard.
  - Response: pc_en=0, ifid_flush=1, idex_en=exmem_en=memwb_en=1.
- Halt:
  - Stimulus: wb_halt=1.
  - Response: next cycle halt=1, all enables and requests 0, sticky for 10 cycles.
  - nRST low mid-cycle clears halt asynchronously.
- With HAZARD_PERF_CNT_EN:
  - Stimulus: 3-cycle miss, 1 branch, 2 bubbles.
  - Response: stall_cycles=3, flush_events=1, bubble_cycles=2.
